fs_accel_wbuf: RTL
==================

Name: fs_accel_wbuf

Overview:
- Parametrised K x K weight-kernel loader/holder for the convolution accelerator.
- Accepts one kernel row (K weights) per valid/ready beat and steers it into row slot 0..K-1 using an internal auto-incrementing row counter; no external select.
- Presents the complete kernel as a flat bus to the MAC array, with a kernel-valid flag and a release handshake.
- Sits between the weight fetch path and the PE array.

Parameters:
- DATA_W, 8, width of one weight in bits.
- K, 3, kernel dimension: rows per kernel and weights per row; legal range 2..7.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- wb_start  in  1  one-cycle request to begin loading a kernel; honoured only in IDLE.
- wb_abort  in  1  synchronous abort of an in-progress load.
- wb_valid  in  1  row beat valid.
- wb_ready  out  1  row beat accepted when wb_valid && wb_ready.
- wb_di  in  K*DATA_W  one row; weight c at bits [c*DATA_W +: DATA_W].
- wb_busy  out  1  high in LOAD and FULL.
- wb_done  out  1  one-cycle pulse on the cycle after the last row is accepted.
- wb_kvalid  out  1  kernel output holds a complete kernel.
- wb_release  in  1  consumer has finished with the presented kernel.
- wb_kernel  out  K*K*DATA_W  weight (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; all-zero whenever wb_kvalid=0.

Behaviour:
- Reset, asynchronous on resetn low:
  - State=IDLE, row_cnt=0.
  - All bank registers = 0.
  - wb_ready=0, wb_busy=0, wb_done=0, wb_kvalid=0.
- States:
  - IDLE: wb_ready=0. wb_start -> LOAD with row_cnt=0.
  - LOAD: wb_ready=1. On each accepted beat, row slot row_cnt <= wb_di and row_cnt increments. When the beat accepted has row_cnt==K-1 -> FULL and row_cnt=0.
  - FULL: wb_ready=0. Exit conditions are mode-dependent (see Optional Feature).
- wb_done: registered; asserted exactly one cycle, on the first cycle in FULL.
- wb_busy: registered state decode.
- Abort: wb_abort in LOAD -> IDLE, row_cnt=0, load bank contents discarded. wb_kvalid is unaffected. wb_abort has priority over a same-cycle beat; that beat is not written. wb_abort in IDLE or FULL is ignored.
- wb_start outside IDLE: ignored, no queuing.
- wb_release while wb_kvalid=0: ignored.
- Latency: a row written on edge N is visible in the bank on edge N+1. wb_kvalid rises on the edge that enters the kernel-valid condition; wb_kernel is registered-bank AND kvalid, with no extra cycle.
- Row counter width: clog2(K); never exceeds K-1.
- Unaccepted beats (wb_valid with wb_ready=0) are dropped by the block. The source must hold data until ready.

Optional Feature:
- Macro: FS_ACCEL_WBUF_DBUF_EN.
- Undefined (single bank):
  - LOAD writes directly into the output bank; wb_kvalid=0 throughout LOAD.
  - Entering FULL sets wb_kvalid=1.
  - In FULL, wb_release -> IDLE with wb_kvalid=0. A new load is possible only after release.
- Defined (double bank):
  - LOAD writes a shadow bank; the active bank and wb_kvalid are untouched during LOAD.
  - In FULL, transfer occurs when (!wb_kvalid || wb_release): active <= shadow, wb_kvalid=1, state -> IDLE.
  - wb_release without a transfer clears wb_kvalid.
  - Release and completion in the same cycle: the transfer wins, and wb_kvalid stays 1 with the new kernel.
  - Allows the next kernel to load while the current one is consumed.

Test Plan:
- Reset mid-LOAD after 2 rows (K=3): resetn low -> next cycle all outputs 0, wb_kernel=0, state IDLE; wb_start then loads normally.
- Single load, K=3, DATA_W=8:
  - Stimulus: wb_start, then rows {0x03,0x02,0x01}, {0x13,0x12,0x11}, {0x23,0x22,0x21}, as wb_di words 0x010203, 0x111213, 0x212223, over 3 consecutive beats.
  - Response: wb_done one pulse; wb_kvalid=1; wb_kernel=0x212223_111213_010203; wb_release -> wb_kvalid=0 and wb_kernel=0.
- Back-pressure: wb_valid toggled 1,0,1,0,1 -> exactly 3 writes; row order preserved; wb_ready drops to 0 in FULL while wb_valid is held high.
- Abort after row 1 with a same-cycle beat -> IDLE; reload with 0xAAAAAA x3 -> kernel all 0xAA; no stale rows.
- wb_start asserted during LOAD and during FULL -> no effect on row_cnt or state.
- DBUF build:
  - Load kernel A, then start kernel B while A is valid and not released -> B completes, state holds FULL, wb_kernel=A.
  - Release -> same cycle transfer: wb_kernel=B, wb_kvalid stays 1, state IDLE.

Source files
------------

// File: rtl/fs_accel_wbuf.sv
// K x K weight-kernel loader/holder: row beats fill the bank in order, and the finished kernel is presented to the MAC array.
// Define FS_ACCEL_WBUF_DBUF_EN to load a shadow bank while the active kernel is still being consumed.
module fs_accel_wbuf #(
    parameter int DATA_W = 8,
    parameter int K      = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wb_start,
    input  logic                    wb_abort,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [K*DATA_W-1:0]     wb_di,
    output logic                    wb_busy,
    output logic                    wb_done,
    output logic                    wb_kvalid,
    input  logic                    wb_release,
    output logic [K*K*DATA_W-1:0]   wb_kernel
);

    localparam int ROW_W = K * DATA_W;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_row_cnt;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_kvalid;
    // Bank written by incoming rows; row r sits at the r-th ROW_W slice.
    logic [K-1:0][ROW_W-1:0]  r_wbank;
    logic [K-1:0][ROW_W-1:0]  w_obank;

    logic w_accept;
    logic w_last;

    assign w_accept = wb_valid && r_ready;
    assign w_last   = (r_row_cnt == LAST_ROW);

`ifdef FS_ACCEL_WBUF_DBUF_EN
    logic [K-1:0][ROW_W-1:0]  r_abank;

    assign w_obank = r_abank;
`else
    assign w_obank = r_wbank;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_kvalid  <= 1'b0;
            // NOTE: the weight banks are plain flops, not RAM, so they are cleared by reset like any other state.
            r_wbank   <= '0;
`ifdef FS_ACCEL_WBUF_DBUF_EN
            r_abank   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_start) begin
                        r_state   <= S_LOAD;
                        r_row_cnt <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (wb_abort) begin
                        r_state   <= S_IDLE;
                        r_row_cnt <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_wbank   <= '0;
                    end else if (w_accept) begin
                        r_wbank[r_row_cnt] <= wb_di;
                        if (w_last) begin
                            r_state   <= S_FULL;
                            r_row_cnt <= '0;
                            r_ready   <= 1'b0;
                            r_done    <= 1'b1;
`ifndef FS_ACCEL_WBUF_DBUF_EN
                            r_kvalid  <= 1'b1;
`endif
                        end else begin
                            r_row_cnt <= r_row_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FULL: begin
`ifdef FS_ACCEL_WBUF_DBUF_EN
                    // Hand the shadow over as soon as the active slot is free or being released.
                    if (!r_kvalid || wb_release) begin
                        r_abank  <= r_wbank;
                        r_kvalid <= 1'b1;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
`else
                    if (wb_release) begin
                        r_kvalid <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
`endif
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_row_cnt <= '0;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
`ifdef FS_ACCEL_WBUF_DBUF_EN
            // Outside FULL a release simply retires the active kernel.
            if (wb_release && r_kvalid && (r_state != S_FULL)) begin
                r_kvalid <= 1'b0;
            end
`endif
        end
    end

    assign wb_ready  = r_ready;
    assign wb_busy   = r_busy;
    assign wb_done   = r_done;
    assign wb_kvalid = r_kvalid;
    assign wb_kernel = r_kvalid ? w_obank : '0;

endmodule
